// File: rtl/dip_pkg.sv
// Shared types and constants for the colour-dip sequencer.
package dip_pkg;

    typedef enum logic [2:0] {
        SELECT,
        MOVE,
        DIP,
        HOME,
        DONE,
        ERR
    } state_t;

    localparam logic [3:0] RED = 4'd1;
    localparam logic [3:0] YEL = 4'd2;
    localparam logic [3:0] BLU = 4'd3;

    localparam int unsigned TIMEOUT_DEF = 500_000_000;

    function automatic logic valid_color(input logic [3:0] c);
        return (c == RED) || (c == YEL) || (c == BLU);
    endfunction

    function automatic logic [2:0] motor_bit(input logic [1:0] c);
        logic [2:0] m;
        m = 3'b000;
        case (c)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dip_timer.sv
// Handshake watchdog: clear/enable counter with an expiry flag.
module dip_timer
    import dip_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [31:0] LAST = 32'(LIMIT - 1);

    logic [31:0] count;
    logic [31:0] base;

    // clr marks the first cycle of a wait, so it counts as cycle zero
    assign base    = clr ? 32'd0 : count;
    assign expired = en && (base == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= base + 32'd1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/dip_sequencer.sv
// Three-slot colour selection and car/motor dipping sequencer.
module dip_sequencer
    import dip_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] color_id,
    input  logic       confirm,
    input  logic       abort,
    output logic       car_req,
    output logic [1:0] car_pos,
    input  logic       car_ack,
    output logic [2:0] motor_start,
    input  logic [2:0] motor_done,
    output logic [3:0] cur_color,
    output logic [1:0] slot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state;
    logic [1:0] slots [3];
    logic       restart;
    logic       wait_st;
    logic       expired;
    logic       awaited;
    logic [1:0] active;
    logic [1:0] next_c;

    assign wait_st = state inside {MOVE, DIP, HOME};
    assign active  = (slot == 2'd3) ? 2'd0 : slots[slot];
    assign next_c  = (slot >= 2'd2) ? 2'd0 : slots[slot + 2'd1];

    // a pulse arriving on the expiry cycle still counts
    assign awaited = ((state == MOVE || state == HOME) && car_ack)
                  || (state == DIP && |(motor_done & motor_bit(active)));

    dip_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (restart),
        .en      (wait_st),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SELECT;
            slots       <= '{default: 2'd0};
            slot        <= 2'd0;
            car_req     <= 1'b0;
            car_pos     <= 2'd0;
            motor_start <= 3'b000;
            cur_color   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            restart     <= 1'b0;
        end else begin
            motor_start <= 3'b000;
            done        <= 1'b0;
            restart     <= 1'b0;
            if (abort) begin
                state     <= SELECT;
                slots     <= '{default: 2'd0};
                slot      <= 2'd0;
                car_req   <= 1'b0;
                car_pos   <= 2'd0;
                cur_color <= 4'd0;
                busy      <= 1'b0;
                err       <= 1'b0;
            end else if (wait_st && expired && !awaited) begin
                state     <= ERR;
                err       <= 1'b1;
                car_req   <= 1'b0;
                cur_color <= 4'd0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    SELECT: begin
                        if (confirm && valid_color(color_id)) begin
                            slots[slot] <= color_id[1:0];
                            if (slot == 2'd2) begin
                                state     <= MOVE;
                                slot      <= 2'd0;
                                car_req   <= 1'b1;
                                car_pos   <= slots[0];
                                cur_color <= {2'b00, slots[0]};
                                busy      <= 1'b1;
                                restart   <= 1'b1;
                            end else begin
                                slot <= slot + 2'd1;
                            end
                        end
                    end
                    MOVE: begin
                        if (car_ack) begin
                            state       <= DIP;
                            car_req     <= 1'b0;
                            motor_start <= motor_bit(active);
                            restart     <= 1'b1;
                        end
                    end
                    DIP: begin
                        if (awaited) begin
                            slot    <= slot + 2'd1;
                            car_req <= 1'b1;
                            restart <= 1'b1;
                            if (slot == 2'd2) begin
                                state     <= HOME;
                                car_pos   <= 2'd0;
                                cur_color <= 4'd0;
                            end else begin
                                state     <= MOVE;
                                car_pos   <= next_c;
                                cur_color <= {2'b00, next_c};
                            end
                        end
                    end
                    HOME: begin
                        if (car_ack) begin
                            state   <= DONE;
                            car_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            slots   <= '{default: 2'd0};
                            slot    <= 2'd0;
                        end
                    end
                    DONE:    state <= SELECT;
                    ERR:     state <= ERR;
                    default: state <= SELECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dip_sequencer.sv
// Self-checking bench for dip_sequencer: vector table, corner sequences, random runs.
`timescale 1ns/1ps
module tb_dip_sequencer;

    localparam int unsigned TMO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] color_id;
    logic       confirm;
    logic       abort;
    logic       car_req;
    logic [1:0] car_pos;
    logic       car_ack;
    logic [2:0] motor_start;
    logic [2:0] motor_done;
    logic [3:0] cur_color;
    logic [1:0] slot;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       conf;
        logic       abt;
        logic [3:0] col;
        logic [1:0] slot;
        logic       busy;
        logic       req;
        logic [1:0] pos;
    } vec_t;

    vec_t vt[$];

    dip_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .color_id    (color_id),
        .confirm     (confirm),
        .abort       (abort),
        .car_req     (car_req),
        .car_pos     (car_pos),
        .car_ack     (car_ack),
        .motor_start (motor_start),
        .motor_done  (motor_done),
        .cur_color   (cur_color),
        .slot        (slot),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot(input int c);
        return 1 << (c - 1);
    endfunction

    function automatic vec_t mk(input int c, input int a, input int col,
                                input int s, input int b, input int r,
                                input int p);
        vec_t v;
        v.conf = c[0];
        v.abt  = a[0];
        v.col  = col[3:0];
        v.slot = s[1:0];
        v.busy = b[0];
        v.req  = r[0];
        v.pos  = p[1:0];
        return v;
    endfunction

    task automatic enter3(input int a, input int b, input int c);
        confirm  = 1'b1;
        color_id = 4'(a);
        step();
        color_id = 4'(b);
        step();
        color_id = 4'(c);
        step();
        confirm  = 1'b0;
        color_id = 4'd0;
    endtask

    // Full run: enter colours, answer handshakes, compare observed events
    // against the list the three chosen colours imply.
    task automatic run_seq(input int c[3], input int dly, input bit rnd,
                           input bit noise, input bit badc);
        int  exp_pos[$];
        int  exp_ms[$];
        int  pos_q[$];
        int  ms_q[$];
        int  badv[3];
        int  ndone;
        int  ack_cnt;
        int  md_cnt;
        int  cyc;
        int  fin_at;
        bit  prev_req;
        bit  ack_sent;
        bit  finished;
        logic [2:0] md_bit;
        badv = '{5, 0, 9};
        for (int i = 0; i < 3; i++) begin
            exp_pos.push_back(c[i]);
            exp_ms.push_back(onehot(c[i]));
        end
        exp_pos.push_back(0);
        ndone = 0; ack_cnt = -1; md_cnt = -1; cyc = 0; fin_at = -1;
        prev_req = 0; ack_sent = 0; finished = 0; md_bit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (badc) begin
                color_id = 4'(badv[i]);
                confirm  = 1'b1;
                step();
                confirm  = 1'b0;
                check("invalid code ignored", int'(slot), i);
            end
            color_id = 4'(c[i]);
            confirm  = 1'b1;
            step();
            confirm  = 1'b0;
            if (i < 2) check("commit slot", int'(slot), i + 1);
            else check("run starts busy", int'(busy), 1);
        end
        while (cyc < 800) begin
            if (ack_sent) begin
                ack_sent = 0;
                check("req drop after ack", int'(car_req), 0);
                if (pos_q[$] != 0)
                    check("start after ack", int'(motor_start),
                          onehot(pos_q[$]));
                else
                    check("done after home ack", int'(done), 1);
            end
            if (ack_cnt >= 0) check("req held", int'(car_req), 1);
            if (car_req && !prev_req) begin
                pos_q.push_back(int'(car_pos));
                check("cur_color", int'(cur_color), int'(car_pos));
                if (car_pos == 2'd0) check("home slot", int'(slot), 3);
                ack_cnt = rnd ? int'($urandom_range(0, 12)) : dly;
            end
            prev_req = car_req;
            if (motor_start != 3'b000) begin
                ms_q.push_back(int'(motor_start));
                md_bit = motor_start;
                md_cnt = rnd ? int'($urandom_range(0, 12)) : dly;
            end
            if (done) begin
                ndone++;
                check("slot at done", int'(slot), 0);
                if (fin_at < 0) fin_at = cyc;
            end
            if (fin_at >= 0 && cyc == fin_at + 3) begin
                finished = 1;
                break;
            end
            car_ack    = 1'b0;
            motor_done = 3'b000;
            confirm    = 1'b0;
            if (ack_cnt == 0) begin
                car_ack  = 1'b1;
                ack_sent = 1;
            end
            if (ack_cnt >= 0) ack_cnt--;
            if (md_cnt == 0) motor_done = md_bit;
            if (md_cnt >= 0) md_cnt--;
            if (noise && ($urandom % 3 == 0))
                motor_done = motor_done | (3'($urandom) & ~md_bit);
            if (noise && busy && ($urandom % 4 == 0)) begin
                confirm  = 1'b1;
                color_id = 4'($urandom_range(1, 3));
            end
            step();
            cyc++;
        end
        car_ack = 1'b0; motor_done = 3'b000; confirm = 1'b0;
        color_id = 4'd0;
        check("run finished", int'(finished), 1);
        check("pos count", pos_q.size(), exp_pos.size());
        for (int i = 0; i < exp_pos.size() && i < pos_q.size(); i++)
            check("car_pos order", pos_q[i], exp_pos[i]);
        check("start count", ms_q.size(), exp_ms.size());
        for (int i = 0; i < exp_ms.size() && i < ms_q.size(); i++)
            check("motor_start order", ms_q[i], exp_ms[i]);
        check("done pulses", ndone, 1);
        check("busy after run", int'(busy), 0);
        check("err after run", int'(err), 0);
    endtask

    initial begin
        int cs[3];
        int nd;
        rst = 1'b1; confirm = 1'b0; abort = 1'b0; car_ack = 1'b0;
        color_id = 4'd0; motor_done = 3'b000;
        repeat (3) step();
        check("rst car_req", int'(car_req), 0);
        check("rst motor_start", int'(motor_start), 0);
        check("rst slot", int'(slot), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'(err), 0);
        check("rst cur_color", int'(cur_color), 0);
        check("rst car_pos", int'(car_pos), 0);
        rst = 1'b0;
        step();

        // select-phase vectors: {confirm, abort, code, slot, busy, req, pos}
        vt.push_back(mk(1, 0, 5, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 2, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 15, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 3, 2, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 2, 0, 1, 1, 3));
        vt.push_back(mk(1, 0, 1, 0, 1, 1, 3));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 3));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < vt.size(); i++) begin
            confirm  = vt[i].conf;
            abort    = vt[i].abt;
            color_id = vt[i].col;
            step();
            check($sformatf("vec%0d slot", i), int'(slot), int'(vt[i].slot));
            check($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].busy));
            check($sformatf("vec%0d req", i), int'(car_req), int'(vt[i].req));
            check($sformatf("vec%0d pos", i), int'(car_pos), int'(vt[i].pos));
        end
        confirm = 1'b0; abort = 1'b0; color_id = 4'd0;

        cs = '{1, 3, 2};
        run_seq(cs, 10, 0, 0, 0);
        cs = '{2, 2, 2};
        run_seq(cs, 3, 0, 0, 1);

        // withheld ack: error exactly TMO cycles after entering MOVE
        enter3(1, 2, 3);
        check("tmo move entered", int'(car_req), 1);
        repeat (99) step();
        check("no err before tmo", int'(err), 0);
        check("req before tmo", int'(car_req), 1);
        step();
        check("err at tmo", int'(err), 1);
        check("req dropped in err", int'(car_req), 0);
        check("busy low in err", int'(busy), 0);
        repeat (5) step();
        check("err sticky", int'(err), 1);
        check("no start in err", int'(motor_start), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort clears err", int'(err), 0);
        check("abort slot", int'(slot), 0);

        // ack on the expiry cycle wins; then DIP times out on its own
        enter3(2, 1, 3);
        repeat (99) step();
        car_ack = 1'b1;
        step();
        car_ack = 1'b0;
        check("ack vs tmo err", int'(err), 0);
        check("ack vs tmo req", int'(car_req), 0);
        check("ack vs tmo start", int'(motor_start), 2);
        repeat (99) step();
        check("dip no err early", int'(err), 0);
        step();
        check("dip err at tmo", int'(err), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // abort during the second dip
        enter3(1, 2, 3);
        car_ack = 1'b1;
        step();
        car_ack = 1'b0;
        check("dip1 start", int'(motor_start), 1);
        motor_done = 3'b001;
        step();
        motor_done = 3'b000;
        check("move2 pos", int'(car_pos), 2);
        check("move2 slot", int'(slot), 1);
        check("move2 color", int'(cur_color), 2);
        car_ack = 1'b1;
        step();
        car_ack = 1'b0;
        check("dip2 start", int'(motor_start), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort dip busy", int'(busy), 0);
        check("abort dip slot", int'(slot), 0);
        check("abort dip req", int'(car_req), 0);
        nd = 0;
        motor_done = 3'b010;
        for (int i = 0; i < 20; i++) begin
            step();
            motor_done = 3'b000;
            if (done) nd++;
        end
        check("no done after abort", nd, 0);

        // asynchronous reset in MOVE, then a clean full run
        enter3(3, 1, 2);
        check("pre-rst req", int'(car_req), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst req", int'(car_req), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst color", int'(cur_color), 0);
        check("async rst pos", int'(car_pos), 0);
        step();
        rst = 1'b0;
        step();
        cs = '{3, 1, 2};
        run_seq(cs, 5, 0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 3; i++) cs[i] = int'($urandom_range(1, 3));
            run_seq(cs, 0, 1, 1, bit'($urandom % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
